// File: rtl/seq_mac_bfusion1d.sv
// seq_mac_bfusion1d
//   Sequencer in front of a bit-fusion MAC (top_mac_bfusion1d). Accepts a
//   valid/ready stream of (w,a) operand pairs and packs them into MAC beats:
//   one pair per beat in 8x8 mode, two pairs per beat in 8x4 mode. Each
//   accumulation group runs CLEAR -> RUN -> DRAIN -> DONE and returns one
//   sign-corrected sum on a valid/ready result port.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, cfg_mode,      start pulse and configuration, sampled only in IDLE
//   cfg_len, cfg_groups   (cfg_len/cfg_groups of 0 are treated as 1)
//   busy                  high from the start edge until the return to IDLE
//   in_valid, in_ready    operand pair handshake
//   in_w, in_a            signed weight (8x4 mode uses in_w[3:0]), unsigned activation
//   mac_mode, mac_accu_rst,
//   mac_w, mac_a          registered drive to the MAC
//   mac_z                 MAC accumulator value
//   out_valid, out_ready  group result handshake
//   out_z                 signed group sum
module seq_mac_bfusion1d #(
  parameter int HEADROOM = 4,
  parameter int LAT      = 3,
  parameter int LEN_W    = 8,
  parameter int GRP_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cfg_mode,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic [GRP_W-1:0]           cfg_groups,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_w,
  input  logic [7:0]                 in_a,
  output logic                       mac_mode,
  output logic                       mac_accu_rst,
  output logic [7:0]                 mac_w,
  output logic [15:0]                mac_a,
  input  logic [16+HEADROOM-1:0]     mac_z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [16+HEADROOM-1:0] out_z
);

  localparam int ZW = 16 + HEADROOM;
  // In 8x4 mode only the low 13+HEADROOM bits of the MAC sum are meaningful.
  localparam int SW = 13 + HEADROOM;
  localparam int DW = $clog2(LAT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic             mode_q;
  logic [LEN_W-1:0] len_q, beat_cnt;
  logic [GRP_W-1:0] grp_q, grp_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             pack_vld;
  logic [3:0]       pack_w;
  logic [7:0]       pack_a;

  logic accept, issue, last_beat, drain_done, handshake, last_grp;

  function automatic logic signed [ZW-1:0] sign_fix(input logic [ZW-1:0] z);
    return $signed({{(ZW-SW){z[SW-1]}}, z[SW-1:0]});
  endfunction

  assign accept     = in_valid & in_ready;
  // In 8x4 mode a beat is only issued when the pack register already holds the upper lanes.
  assign issue      = accept & (~mode_q | pack_vld);
  assign last_beat  = issue & (beat_cnt == len_q);
  assign drain_done = (state == DRAIN) && (drain_cnt == DW'(LAT));
  assign handshake  = out_valid & out_ready;
  assign last_grp   = (grp_cnt == grp_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)      state_nx = CLEAR;
      CLEAR:                   state_nx = RUN;
      RUN:     if (last_beat)  state_nx = DRAIN;
      DRAIN:   if (drain_done) state_nx = DONE;
      DONE:    if (handshake)  state_nx = last_grp ? IDLE : CLEAR;
      default:                 state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state != IDLE);
    in_ready  = (state == RUN);
    out_valid = (state == DONE);
  end

  assign mac_mode = mode_q;

  // Control registers: configuration, counters, pack occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= 1'b0;
      len_q        <= '0;
      grp_q        <= '0;
      beat_cnt     <= '0;
      grp_cnt      <= '0;
      drain_cnt    <= '0;
      pack_vld     <= 1'b0;
      mac_accu_rst <= 1'b0;
    end else begin
      mac_accu_rst <= (state_nx == CLEAR);
      unique case (state)
        IDLE: if (start) begin
          mode_q  <= cfg_mode;
          len_q   <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
          grp_q   <= (cfg_groups == '0) ? GRP_W'(1) : cfg_groups;
          grp_cnt <= GRP_W'(1);
        end
        CLEAR: begin
          beat_cnt <= LEN_W'(1);
          pack_vld <= 1'b0;
        end
        RUN: if (accept) begin
          pack_vld <= mode_q & ~pack_vld;
          if (last_beat)  drain_cnt <= DW'(1);
          else if (issue) beat_cnt  <= beat_cnt + LEN_W'(1);
        end
        DRAIN: if (!drain_done) drain_cnt <= drain_cnt + DW'(1);
        DONE: if (handshake && !last_grp) grp_cnt <= grp_cnt + GRP_W'(1);
        default: ;
      endcase
    end
  end

  // Pack register for the upper lanes of an 8x4 beat; occupancy is tracked by pack_vld
  always_ff @(posedge clk) begin
    if (accept && mode_q && !pack_vld) begin
      pack_w <= in_w[3:0];
      pack_a <= in_a;
    end
  end

  // Beat issue stage: operands default to zero so idle cycles add nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_w <= '0;
      mac_a <= '0;
    end else begin
      mac_w <= '0;
      mac_a <= '0;
      if (issue) begin
        if (mode_q) begin
          mac_w <= {pack_w, in_w[3:0]};
          mac_a <= {pack_a, in_a};
        end else begin
          mac_w <= in_w;
          mac_a <= {8'h00, in_a};
        end
      end
    end
  end

  // Result capture on the LAT-th edge after the last beat edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          out_z <= '0;
    else if (drain_done) out_z <= mode_q ? sign_fix(mac_z) : $signed(mac_z);
  end

endmodule

// File: tb/tb_seq_mac_bfusion1d.sv
module tb_seq_mac_bfusion1d;

  localparam int HEADROOM = 4;
  localparam int ZW = 16 + HEADROOM;
  localparam int SW = 13 + HEADROOM;

  logic clk = 1'b0;
  logic rst_n, start, cfg_mode, in_valid, out_ready;
  logic [7:0] cfg_len, cfg_groups, in_w, in_a;
  logic busy, in_ready, mac_mode, mac_accu_rst, out_valid;
  logic [7:0] mac_w;
  logic [15:0] mac_a;
  logic [ZW-1:0] mac_z;
  logic signed [ZW-1:0] out_z;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_mac_bfusion1d #(.HEADROOM(HEADROOM), .LAT(3), .LEN_W(8), .GRP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode),
    .cfg_len(cfg_len), .cfg_groups(cfg_groups), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_a(in_a),
    .mac_mode(mac_mode), .mac_accu_rst(mac_accu_rst), .mac_w(mac_w),
    .mac_a(mac_a), .mac_z(mac_z), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z)
  );

  // MAC model: beat on mac_* after edge e, product registered at e+1,
  // accumulated at e+2, so the sum is visible before edge e+3.
  logic signed [ZW-1:0] prod_p1, acc;

  function automatic logic signed [ZW-1:0] mac_prod(input logic m, input logic [7:0] w,
                                                     input logic [15:0] a);
    int r;
    if (!m) r = int'($signed(w)) * int'(a[7:0]);
    else    r = int'($signed(w[7:4])) * int'(a[15:8]) + int'($signed(w[3:0])) * int'(a[7:0]);
    return ZW'(r);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p1 <= '0;
      acc     <= '0;
    end else begin
      prod_p1 <= mac_prod(mac_mode, mac_w, mac_a);
      acc     <= mac_accu_rst ? '0 : acc + prod_p1;
    end
  end

  // In 8x4 mode the fused MAC's upper bits are not meaningful; invert them here
  // so a missing sign correction shows up.
  assign mac_z = mac_mode ? {~acc[ZW-1:SW], acc[SW-1:0]} : acc;

  typedef struct { logic [7:0] w; logic [7:0] a; } pair_t;
  typedef struct { logic mode; logic [7:0] len; int first; int np; int exp_z; } vec_t;

  pair_t pt [16];
  vec_t  vt [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic m, input logic [7:0] len, input logic [7:0] grp);
    cfg_mode = m; cfg_len = len; cfg_groups = grp;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_mode = 1'b0; cfg_len = 8'd0; cfg_groups = 8'd0;
  endtask

  task automatic send_pair(input string nm, input logic [7:0] w, input logic [7:0] a);
    int guard;
    in_w = w; in_a = a; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    check({nm, "_in_ready"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int guard;
    guard = 0;
    while (!out_valid && guard < 40) begin
      tick();
      guard++;
    end
    check({nm, "_out_valid"}, int'(out_valid), 1);
  endtask

  task automatic get_result(input string nm, input int exp);
    wait_valid(nm);
    check({nm, "_z"}, int'(out_z), exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, "_valid_fall"}, int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_mode = 1'b0; cfg_len = 8'd0; cfg_groups = 8'd0;
    in_valid = 1'b0; in_w = 8'd0; in_a = 8'd0; out_ready = 1'b0;

    pt[0]  = '{8'hFD, 8'd200}; pt[1]  = '{8'h05, 8'd10};
    pt[2]  = '{8'hF8, 8'd255}; pt[3]  = '{8'h07, 8'd3};
    pt[4]  = '{8'h80, 8'd255};
    pt[5]  = '{8'hF8, 8'd255}; pt[6]  = '{8'hF8, 8'd255};
    pt[7]  = '{8'hF8, 8'd255}; pt[8]  = '{8'hF8, 8'd255};
    pt[9]  = '{8'h57, 8'd17};  pt[10] = '{8'hAF, 8'd2};
    pt[11] = '{8'h7F, 8'd1};   pt[12] = '{8'h7F, 8'd2};   pt[13] = '{8'hFF, 8'd3};
    pt[14] = '{8'h00, 8'd0};   pt[15] = '{8'h00, 8'd0};

    vt[0] = '{1'b0, 8'd2, 0,  2, -550};    // -3*200 + 5*10
    vt[1] = '{1'b1, 8'd1, 2,  2, -2019};   // -8*255 + 7*3
    vt[2] = '{1'b0, 8'd0, 4,  1, -32640};  // len 0 -> 1 beat, -128*255
    vt[3] = '{1'b1, 8'd2, 5,  4, -8160};   // 4 * (-8*255)
    vt[4] = '{1'b1, 8'd1, 9,  2, 117};     // upper nibbles ignored: 7*17 + -1*2
    vt[5] = '{1'b0, 8'd3, 11, 3, 378};     // 127 + 254 - 3

    tick(); tick();
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_accu_rst", int'(mac_accu_rst), 0);
    check("rst_mac_w", int'(mac_w), 0);
    check("rst_mac_a", int'(mac_a), 0);
    check("rst_out_z", int'(out_z), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_start(vt[i].mode, vt[i].len, 8'd1);
      check($sformatf("vec%0d_busy", i), int'(busy), 1);
      for (int j = 0; j < vt[i].np; j++)
        send_pair($sformatf("vec%0d_p%0d", i, j), pt[vt[i].first + j].w, pt[vt[i].first + j].a);
      get_result($sformatf("vec%0d", i), vt[i].exp_z);
      check($sformatf("vec%0d_busy_end", i), int'(busy), 0);
    end

    // 8x4 beat packing on the MAC port
    do_start(1'b1, 8'd1, 8'd1);
    send_pair("t2_p0", 8'hF8, 8'd255);
    check("t2_half_w", int'(mac_w), 0);
    send_pair("t2_p1", 8'h07, 8'd3);
    check("t2_mac_w", int'(mac_w), 'h87);
    check("t2_mac_a", int'(mac_a), 'hFF03);
    check("t2_mac_mode", int'(mac_mode), 1);
    check("t2_in_ready_drop", int'(in_ready), 0);
    get_result("t2", -2019);

    // Input gap: zero operands while in_valid is low
    do_start(1'b0, 8'd2, 8'd1);
    send_pair("t3_p0", 8'hFD, 8'd200);
    check("t3_beat_w", int'(mac_w), 'hFD);
    check("t3_beat_a", int'(mac_a), 200);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t3_gap%0d_w", k), int'(mac_w), 0);
      check($sformatf("t3_gap%0d_a", k), int'(mac_a), 0);
    end
    send_pair("t3_p1", 8'h05, 8'd10);
    get_result("t3", -550);
    check("t3_busy_end", int'(busy), 0);

    // Two groups with back-pressure on the first result
    do_start(1'b0, 8'd1, 8'd2);
    send_pair("t4_p0", 8'd100, 8'd1);
    wait_valid("t4_g0");
    for (int k = 0; k < 5; k++) begin
      start = (k == 0); cfg_mode = 1'b1; cfg_len = 8'd7;
      tick();
      start = 1'b0; cfg_mode = 1'b0; cfg_len = 8'd0;
      check($sformatf("t4_hold%0d_valid", k), int'(out_valid), 1);
      check($sformatf("t4_hold%0d_z", k), int'(out_z), 100);
      check($sformatf("t4_hold%0d_in_ready", k), int'(in_ready), 0);
      check($sformatf("t4_hold%0d_accu_rst", k), int'(mac_accu_rst), 0);
      check($sformatf("t4_hold%0d_mode", k), int'(mac_mode), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_valid_fall", int'(out_valid), 0);
    check("t4_clear", int'(mac_accu_rst), 1);
    check("t4_busy_mid", int'(busy), 1);
    send_pair("t4_p1", 8'hF9, 8'd2);
    get_result("t4_g1", -14);
    check("t4_busy_end", int'(busy), 0);

    // Half-packed beat waits in RUN
    do_start(1'b1, 8'd3, 8'd1);
    for (int j = 0; j < 5; j++)
      send_pair($sformatf("t5_p%0d", j), 8'h01, 8'(j + 1));
    tick(); tick(); tick();
    check("t5_stall_in_ready", int'(in_ready), 1);
    check("t5_stall_busy", int'(busy), 1);
    check("t5_stall_out_valid", int'(out_valid), 0);
    check("t5_stall_mac_w", int'(mac_w), 0);
    send_pair("t5_p5", 8'h01, 8'd6);
    get_result("t5", 21);

    // Asynchronous reset mid-run, then a fresh start
    do_start(1'b1, 8'd2, 8'd1);
    send_pair("t6_p0", 8'hF8, 8'd255);
    send_pair("t6_p1", 8'h07, 8'd3);
    rst_n = 1'b0;
    #1;
    check("t6_busy", int'(busy), 0);
    check("t6_in_ready", int'(in_ready), 0);
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_accu_rst", int'(mac_accu_rst), 0);
    check("t6_mac_mode", int'(mac_mode), 0);
    check("t6_mac_w", int'(mac_w), 0);
    check("t6_mac_a", int'(mac_a), 0);
    check("t6_out_z", int'(out_z), 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(1'b0, 8'd2, 8'd1);
    send_pair("t6_r0", 8'hFD, 8'd200);
    send_pair("t6_r1", 8'h05, 8'd10);
    get_result("t6", -550);
    check("t6_busy_end", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
